ecpddr_rdcal: RTL and testbench
===============================

# ecpddr_rdcal

Read-leveling calibration sequencer for the ECP5 DDR3 PHY. After reset or on request, it waits for the DDRDLLA to lock and pulses a DLL code update under freeze. It then sweeps the DQSBUFM READCLKSEL setting 0..7 on every lane, issuing one training read burst per setting and recording BURSTDET per lane. Finally it programs each lane to the centre of its widest passing window. It sits between the DDR3 controller's init engine (which services the training reads) and the per-lane PHY control pins.

## Interface
- NLANES, 2, number of byte lanes
- LOCK_WAIT, 1024, max cycles to wait for i_dll_lock before failing
- PAUSE_CYCLES, 4, o_pause high time per READCLKSEL change (≥3)
- SETTLE_CYCLES, 8, idle cycles after pause before a training read
- RD_TIMEOUT, 255, max cycles from o_rd_req rise to i_rd_ack

Ports:
- i_clk  in  1  system clock (SCLK domain). One clock; reset is asynchronous and active-high.
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start calibration; ignored while o_busy
- o_busy  out  1  calibration in progress
- o_done  out  1  one-cycle pulse on successful completion
- o_err  out  1  sticky failure flag; cleared on next i_start
- i_dll_lock  in  1  DDRDLLA LOCK
- o_dll_freeze  out  1  DDRDLLA FREEZE
- o_dll_update  out  1  DDRDLLA update request (active high; PHY inverts to UDDCNTLN)
- o_pause  out  1  DQSBUFM PAUSE, all lanes
- o_rdsel  out  NLANES*3  READCLKSEL per lane, lane n at [3n+2:3n]
- o_rd_req  out  1  request one training read burst
- i_rd_ack  in  1  one-cycle pulse: burst completed, BURSTDET valid
- i_burstdet  in  NLANES  DQSBUFM BURSTDET per lane
- o_pass_map  out  NLANES*8  per-lane pass bitmap, bit k = setting k passed

## Operation
- States: IDLE, LOCKWAIT, DLLUPD, SETSEL, SETTLE, READ, CHECK, EVAL, APPLY, DONE, FAIL.
- Reset: all outputs 0; state IDLE; sweep index 0. Reset is asynchronous and takes effect mid-operation with no cleanup.
- IDLE: i_start=1 → LOCKWAIT, o_busy=1, o_err=0, o_pass_map=0.
- LOCKWAIT: i_dll_lock=1 → DLLUPD. LOCK_WAIT cycles without lock → FAIL.
- DLLUPD: 4 cycles. o_dll_freeze=1 in all four; o_dll_update=1 in cycles 1–2 only; then → SETSEL with index k=0.
- SETSEL: o_pause=1 for PAUSE_CYCLES cycles. o_rdsel is loaded with k on all lanes at the edge ending pause cycle 0, so it never changes while o_pause=0. → SETTLE.
- SETTLE: SETTLE_CYCLES idle, then → READ.
- READ: o_rd_req=1 held until i_rd_ack is sampled high, then drops the next cycle. An ack coinciding with the first request cycle is legal. Timeout (RD_TIMEOUT) → FAIL.
- CHECK (one cycle, the cycle after ack): o_pass_map[8n+k] ← i_burstdet[n]. If k=7 → EVAL, else k←k+1 → SETSEL.
- EVAL, per lane:
  - find the longest run of consecutive 1s in the 8-bit map; no wrap-around.
  - ties → the run with the lowest start.
  - centre = start + floor((len−1)/2).
  - any lane with an all-zero map → FAIL.
- APPLY: same pause protocol as SETSEL, loading the per-lane centres → DONE.
- DONE: o_done=1 for one cycle, o_busy=0 → IDLE.
- FAIL: o_err=1, o_rdsel=0, o_busy=0 → IDLE; o_pass_map retained.

## Timing
- All outputs registered; no combinational input→output paths.
- Sweep cost per setting: PAUSE_CYCLES + SETTLE_CYCLES + read latency + 1.
- o_pass_map is valid after CHECK of k=7 and holds until the next i_start.
- A simultaneous i_start with DONE/FAIL exit is ignored; IDLE must be observed first.

## Configuration
- ECPDDR_RDCAL_RETRY_EN defined: on an EVAL failure (some lane all-zero), clear o_pass_map, reset k=0 and re-run from DLLUPD. Up to 3 total sweeps, then FAIL. A 2-bit attempt counter resets on i_start.
- Not defined: first EVAL failure → FAIL directly.

## Test plan
- Lock at cycle 10; lane0 passes settings 2–5, lane1 passes 4–7 → o_pass_map={8'hF0,8'h3C}, o_rdsel lane0=3, lane1=5, o_done pulse, o_err=0.
- Lane0 passes {1,2} and {4,5,6} → longest run {4,5,6} is chosen, lane0 o_rdsel=5; a single-pass lane at 7 → 7.
- i_dll_lock held 0 with LOCK_WAIT=64 → o_err=1 exactly 64 cycles after LOCKWAIT entry; o_rd_req never asserted.
- i_rd_ack withheld at k=3 → FAIL after RD_TIMEOUT; o_rdsel=0, o_pass_map[2:0]=3'b111 when passes were fed for 0–2.
- Assert i_rst during READ → all outputs 0 asynchronously, before the next edge; new i_start → full sequence from LOCKWAIT.
- Lane1 all-zero on sweep 1, passes 2–4 on sweep 2: with ECPDDR_RDCAL_RETRY_EN, two DLLUPD sequences then o_done and lane1 o_rdsel=3; without the macro, o_err=1 after the first sweep.

Source files
------------

// File: rtl/ecpddr_rdcal.sv
// ecpddr_rdcal - read-leveling calibration sequencer for the ECP5 DDR3 PHY.
//
// After i_start the sequencer waits for DDRDLLA lock and issues a frozen
// DLL code update. It then steps READCLKSEL 0..7 on all lanes, requests one
// training read per setting and records BURSTDET per lane. Finally each lane
// is programmed to the centre of its longest run of passing settings.
//
// Optional feature macro: ECPDDR_RDCAL_RETRY_EN
//   defined     - a lane with no passing setting restarts the sweep from the
//                 DLL update, up to 3 sweeps in total, before failing.
//   not defined - a lane with no passing setting fails immediately.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           start calibration (ignored unless idle)
//   o_busy            calibration in progress
//   o_done            one-cycle success pulse
//   o_err             sticky failure flag, cleared by the next i_start
//   i_dll_lock        DDRDLLA LOCK
//   o_dll_freeze      DDRDLLA FREEZE
//   o_dll_update      DDRDLLA code update request (active high)
//   o_pause           DQSBUFM PAUSE, shared by all lanes
//   o_rdsel           READCLKSEL, lane n at [3n+2:3n]
//   o_rd_req          request one training read burst
//   i_rd_ack          one-cycle pulse, burst done and i_burstdet valid
//   i_burstdet        DQSBUFM BURSTDET per lane
//   o_pass_map        per-lane pass bitmap, lane n at [8n+7:8n]
module ecpddr_rdcal #(
    parameter int NLANES        = 2,
    parameter int LOCK_WAIT     = 1024,
    parameter int PAUSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int RD_TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    input  logic                  i_dll_lock,
    output logic                  o_dll_freeze,
    output logic                  o_dll_update,
    output logic                  o_pause,
    output logic [NLANES*3-1:0]   o_rdsel,
    output logic                  o_rd_req,
    input  logic                  i_rd_ack,
    input  logic [NLANES-1:0]     i_burstdet,
    output logic [NLANES*8-1:0]   o_pass_map
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOCKWAIT = 4'd1;
    localparam logic [3:0] S_DLLUPD   = 4'd2;
    localparam logic [3:0] S_SETSEL   = 4'd3;
    localparam logic [3:0] S_SETTLE   = 4'd4;
    localparam logic [3:0] S_READ     = 4'd5;
    localparam logic [3:0] S_CHECK    = 4'd6;
    localparam logic [3:0] S_EVAL     = 4'd7;
    localparam logic [3:0] S_APPLY    = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;
    localparam logic [3:0] S_FAIL     = 4'd10;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST  = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_TIMEOUT - 1);

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;      // per-state cycle counter
    logic [2:0]       k;        // sweep index
    logic [NLANES-1:0] det_q;   // BURSTDET captured with the ack
`ifdef ECPDDR_RDCAL_RETRY_EN
    logic [1:0]       attempt;  // completed sweeps that ended with a dead lane
`endif

    logic [NLANES*3-1:0] centre_c;
    logic                any_zero_c;

    // Centre of the longest run of 1s (no wrap). A strict '>' keeps the
    // earliest run on ties.
    function automatic logic [2:0] centre_of(input logic [7:0] map);
        int best_len;
        int best_start;
        int run_len;
        int run_start;
        // NOTE: function/combinational variables use blocking '=' so each
        // statement sees the value computed by the previous one.
        best_len   = 0;
        best_start = 0;
        run_len    = 0;
        run_start  = 0;
        for (int i = 0; i < 8; i++) begin
            if (map[i]) begin
                if (run_len == 0) run_start = i;
                run_len = run_len + 1;
                if (run_len > best_len) begin
                    best_len   = run_len;
                    best_start = run_start;
                end
            end else begin
                run_len = 0;
            end
        end
        if (best_len == 0) return 3'd0;
        return 3'(best_start + (best_len - 1) / 2);
    endfunction

    // The map is stable from EVAL through APPLY, so the centres are derived
    // straight from it rather than stored separately.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        centre_c   = '0;
        any_zero_c = 1'b0;
        for (int n = 0; n < NLANES; n++) begin
            centre_c[3*n +: 3] = centre_of(o_pass_map[8*n +: 8]);
            if (o_pass_map[8*n +: 8] == 8'h00) any_zero_c = 1'b1;
        end
    end

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // '<=' so every register updates from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            k            <= '0;
            det_q        <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_dll_freeze <= 1'b0;
            o_dll_update <= 1'b0;
            o_pause      <= 1'b0;
            o_rdsel      <= '0;
            o_rd_req     <= 1'b0;
            o_pass_map   <= '0;
`ifdef ECPDDR_RDCAL_RETRY_EN
            attempt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state      <= S_LOCKWAIT;
                        cnt        <= '0;
                        o_busy     <= 1'b1;
                        o_err      <= 1'b0;
                        o_pass_map <= '0;
`ifdef ECPDDR_RDCAL_RETRY_EN
                        attempt    <= '0;
`endif
                    end
                end

                S_LOCKWAIT: begin
                    if (i_dll_lock) begin
                        state        <= S_DLLUPD;
                        cnt          <= '0;
                        o_dll_freeze <= 1'b1;
                    end else if (cnt == LOCK_LAST) begin
                        // Failure outputs are set on the transition itself so
                        // o_err rises exactly LOCK_WAIT cycles after entry.
                        state    <= S_FAIL;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_rdsel  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Freeze spans all four cycles; update only the middle two,
                // so the code moves only while the delay lines are frozen.
                S_DLLUPD: begin
                    cnt          <= cnt + 1'b1;
                    o_dll_update <= (cnt == 16'd0) || (cnt == 16'd1);
                    if (cnt == 16'd3) begin
                        state        <= S_SETSEL;
                        cnt          <= '0;
                        k            <= '0;
                        o_dll_freeze <= 1'b0;
                        o_dll_update <= 1'b0;
                        o_pause      <= 1'b1;
                    end
                end

                // READCLKSEL changes only inside the pause window.
                S_SETSEL: begin
                    if (cnt == '0) o_rdsel <= {NLANES{k}};
                    if (cnt == PAUSE_LAST) begin
                        state   <= S_SETTLE;
                        cnt     <= '0;
                        o_pause <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state    <= S_READ;
                        cnt      <= '0;
                        o_rd_req <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_READ: begin
                    if (i_rd_ack) begin
                        state    <= S_CHECK;
                        o_rd_req <= 1'b0;
                        det_q    <= i_burstdet;
                    end else if (cnt == RD_LAST) begin
                        state    <= S_FAIL;
                        o_rd_req <= 1'b0;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_rdsel  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    for (int n = 0; n < NLANES; n++)
                        o_pass_map[8*n + int'(k)] <= det_q[n];
                    if (k == 3'd7) begin
                        state <= S_EVAL;
                    end else begin
                        state   <= S_SETSEL;
                        k       <= k + 3'd1;
                        cnt     <= '0;
                        o_pause <= 1'b1;
                    end
                end

                S_EVAL: begin
                    if (any_zero_c) begin
`ifdef ECPDDR_RDCAL_RETRY_EN
                        if (attempt != 2'd2) begin
                            attempt      <= attempt + 2'd1;
                            state        <= S_DLLUPD;
                            cnt          <= '0;
                            k            <= '0;
                            o_pass_map   <= '0;
                            o_dll_freeze <= 1'b1;
                        end else begin
                            state   <= S_FAIL;
                            o_err   <= 1'b1;
                            o_busy  <= 1'b0;
                            o_rdsel <= '0;
                        end
`else
                        state   <= S_FAIL;
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        o_rdsel <= '0;
`endif
                    end else begin
                        state   <= S_APPLY;
                        cnt     <= '0;
                        o_pause <= 1'b1;
                    end
                end

                S_APPLY: begin
                    if (cnt == '0) o_rdsel <= centre_c;
                    if (cnt == PAUSE_LAST) begin
                        state   <= S_DONE;
                        o_pause <= 1'b0;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Both terminal states return to IDLE unconditionally, so a
                // start coinciding with the exit is not seen.
                S_DONE: begin
                    o_done <= 1'b0;
                    state  <= S_IDLE;
                end

                S_FAIL: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecpddr_rdcal.sv
// Directed testbench for ecpddr_rdcal. A background responder acts as the
// controller/PHY pair: it acks training reads and returns BURSTDET from
// per-lane pass maps chosen by each test.
module tb_ecpddr_rdcal;

    localparam int NLANES = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_dll_lock = 1'b0;
    logic                 i_rd_ack = 1'b0;
    logic [NLANES-1:0]    i_burstdet = '0;
    logic                 o_busy, o_done, o_err;
    logic                 o_dll_freeze, o_dll_update, o_pause, o_rd_req;
    logic [NLANES*3-1:0]  o_rdsel;
    logic [NLANES*8-1:0]  o_pass_map;

    int errors = 0;
    int checks = 0;

    // Responder configuration (written by the main sequence only).
    logic [7:0] map_a [NLANES];  // maps for the first sweep
    logic [7:0] map_b [NLANES];  // maps for later sweeps
    int         ack_lat = 0;
    bit         withhold_en = 1'b0;
    logic [2:0] withhold_k = 3'd0;
    int         sweep_base = 0;
    int         upd_base = 0;

    // Written by background processes only.
    int sweeps_done = 0;
    int upd_total = 0;
    int rdsel_viol = 0;

    ecpddr_rdcal #(
        .NLANES(NLANES), .LOCK_WAIT(64), .PAUSE_CYCLES(4),
        .SETTLE_CYCLES(8), .RD_TIMEOUT(255)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .i_dll_lock(i_dll_lock), .o_dll_freeze(o_dll_freeze),
        .o_dll_update(o_dll_update), .o_pause(o_pause), .o_rdsel(o_rdsel),
        .o_rd_req(o_rd_req), .i_rd_ack(i_rd_ack), .i_burstdet(i_burstdet),
        .o_pass_map(o_pass_map)
    );

    always #5 i_clk = ~i_clk;

    // Read responder.
    initial begin : responder
        int         seen;
        logic [2:0] sel;
        logic [7:0] m;
        seen = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                i_rd_ack = 1'b0;
                seen = 0;
            end else if (i_rd_ack) begin
                i_rd_ack = 1'b0;
                seen = 0;
            end else if (o_rd_req) begin
                if (seen >= ack_lat && !(withhold_en && o_rdsel[2:0] == withhold_k)) begin
                    sel = o_rdsel[2:0];
                    for (int n = 0; n < NLANES; n++) begin
                        m = (sweeps_done == sweep_base) ? map_a[n] : map_b[n];
                        i_burstdet[n] = m[sel];
                    end
                    i_rd_ack = 1'b1;
                    if (sel == 3'd7) sweeps_done++;
                end else begin
                    seen++;
                end
            end else begin
                seen = 0;
            end
        end
    end

    // Counts DLL update pulses and READCLKSEL changes outside a pause window.
    initial begin : monitor
        logic                prev_upd;
        logic [NLANES*3-1:0] prev_sel;
        prev_upd = 1'b0;
        prev_sel = '0;
        forever begin
            @(negedge i_clk);
            if (o_dll_update === 1'b1 && prev_upd !== 1'b1) upd_total++;
            if (!i_rst && o_err !== 1'b1 && o_rdsel !== prev_sel && o_pause !== 1'b1)
                rdsel_viol++;
            prev_upd = o_dll_update;
            prev_sel = o_rdsel;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic start_cal();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit done_seen, output bit err_seen);
        done_seen = 1'b0;
        err_seen  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) begin done_seen = 1'b1; break; end
            if (o_err === 1'b1) begin err_seen = 1'b1; break; end
        end
    endtask

    task automatic set_maps(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1);
        map_a[0] = a0; map_a[1] = a1;
        map_b[0] = b0; map_b[1] = b1;
        sweep_base = sweeps_done;
        upd_base   = upd_total;
    endtask

    // Successful calibration with the given maps; checks done, map, centres.
    task automatic run_and_check(input string name, input logic [15:0] exp_map,
                                 input logic [5:0] exp_sel);
        bit d, e;
        start_cal();
        checks++;
        if (o_busy !== 1'b1 || o_pass_map !== 16'h0000) begin
            errors++;
            $display("FAIL %s_start: busy=%b map=%h, want busy=1 map=0000", name, o_busy, o_pass_map);
        end
        wait_end(3000, d, e);
        checks++;
        if (d !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b err=%b busy=%b, want 1/0/0", name, d, o_err, o_busy);
        end
        checks++;
        if (o_pass_map !== exp_map) begin
            errors++;
            $display("FAIL %s_map: got %h want %h", name, o_pass_map, exp_map);
        end
        checks++;
        if (o_rdsel !== exp_sel) begin
            errors++;
            $display("FAIL %s_rdsel: got %h want %h", name, o_rdsel, exp_sel);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_rdsel !== exp_sel || o_pass_map !== exp_map) begin
            errors++;
            $display("FAIL %s_hold: done=%b rdsel=%h map=%h, want 0/%h/%h",
                     name, o_done, o_rdsel, o_pass_map, exp_sel, exp_map);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_done, o_err, o_dll_freeze, o_dll_update, o_pause, o_rd_req} !== 7'b0 ||
            o_rdsel !== '0 || o_pass_map !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b rdsel=%h map=%h, want all zero",
                     {o_busy, o_done, o_err, o_dll_freeze, o_dll_update, o_pause, o_rd_req},
                     o_rdsel, o_pass_map);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    // Lock arrives 10 cycles in; lane0 passes 2-5, lane1 passes 4-7.
    task automatic test_basic();
        bit d, e;
        set_maps(8'h3C, 8'hF0, 8'h3C, 8'hF0);
        i_dll_lock = 1'b0;
        start_cal();
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_dll_freeze !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_lockwait: freeze=%b busy=%b, want 0/1", o_dll_freeze, o_busy);
        end
        i_dll_lock = 1'b1;
        wait_end(3000, d, e);
        checks++;
        if (d !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b err=%b busy=%b, want 1/0/0", d, o_err, o_busy);
        end
        checks++;
        if (o_pass_map !== 16'hF03C) begin
            errors++;
            $display("FAIL basic_map: got %h want f03c", o_pass_map);
        end
        checks++;
        if (o_rdsel !== 6'o53) begin
            errors++;
            $display("FAIL basic_rdsel: got %o want 53 (lane1=5 lane0=3)", o_rdsel);
        end
        checks++;
        if (upd_total - upd_base !== 1) begin
            errors++;
            $display("FAIL basic_dll_updates: got %0d want 1", upd_total - upd_base);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done still %b one cycle later, want 0", o_done);
        end
    endtask

    // Two runs on lane0 ({1,2} and {4,5,6}), single pass at 7 on lane1;
    // then equal-length runs ({0,1},{3,4}) and an all-pass lane.
    task automatic test_multi_run();
        set_maps(8'h76, 8'h80, 8'h76, 8'h80);
        ack_lat = 2;
        run_and_check("longest", 16'h8076, 6'o75);
        set_maps(8'h1B, 8'hFF, 8'h1B, 8'hFF);
        ack_lat = 0;
        run_and_check("tie", 16'hFF1B, 6'o30);
    endtask

    task automatic test_lock_timeout();
        bit req_seen;
        req_seen = 1'b0;
        i_dll_lock = 1'b0;
        start_cal();
        for (int j = 1; j <= 64; j++) begin
            @(negedge i_clk);
            if (o_rd_req === 1'b1) req_seen = 1'b1;
            if (j == 63) begin
                checks++;
                if (o_err !== 1'b0 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_early: err=%b busy=%b at cycle 63, want 0/1", o_err, o_busy);
                end
            end
        end
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_rdsel !== '0) begin
            errors++;
            $display("FAIL lock_timeout: err=%b busy=%b rdsel=%h at cycle 64, want 1/0/00",
                     o_err, o_busy, o_rdsel);
        end
        checks++;
        if (req_seen !== 1'b0) begin
            errors++;
            $display("FAIL lock_no_read: rd_req seen=%b, want 0", req_seen);
        end
        i_dll_lock = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    // Reads at settings 0-2 succeed with all lanes passing; setting 3 is never acked.
    task automatic test_rd_timeout();
        bit found;
        int n;
        set_maps(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        withhold_en = 1'b1;
        withhold_k  = 3'd3;
        start_cal();
        checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rdto_err_clear: err=%b busy=%b after start, want 0/1", o_err, o_busy);
        end
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge i_clk);
            if (o_rd_req === 1'b1 && o_rdsel[2:0] == 3'd3) begin found = 1'b1; break; end
        end
        n = 0;
        if (found) begin
            for (int i = 0; i < 400; i++) begin
                @(negedge i_clk);
                n++;
                if (o_err === 1'b1) break;
            end
        end
        checks++;
        if (n !== 255 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL rdto_latency: err=%b after %0d cycles (req found=%b), want err=1 after 255",
                     o_err, n, found);
        end
        checks++;
        if (o_rdsel !== '0 || o_busy !== 1'b0 || o_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL rdto_outputs: rdsel=%h busy=%b rd_req=%b, want 00/0/0",
                     o_rdsel, o_busy, o_rd_req);
        end
        checks++;
        if (o_pass_map !== 16'h0707) begin
            errors++;
            $display("FAIL rdto_map: got %h want 0707", o_pass_map);
        end
        withhold_en = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_async_reset();
        bit found;
        set_maps(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        ack_lat = 3;
        start_cal();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge i_clk);
            if (o_rd_req === 1'b1 && o_rdsel[2:0] == 3'd2) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || o_pass_map !== 16'h0303) begin
            errors++;
            $display("FAIL arst_setup: read at 2 found=%b map=%h, want 1/0303", found, o_pass_map);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_err, o_dll_freeze, o_dll_update, o_pause, o_rd_req} !== 7'b0 ||
            o_rdsel !== '0 || o_pass_map !== '0) begin
            errors++;
            $display("FAIL arst_async: ctl=%b rdsel=%h map=%h before next edge, want all zero",
                     {o_busy, o_done, o_err, o_dll_freeze, o_dll_update, o_pause, o_rd_req},
                     o_rdsel, o_pass_map);
        end
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        set_maps(8'h3C, 8'hF0, 8'h3C, 8'hF0);
        ack_lat = 0;
        run_and_check("arst_rerun", 16'hF03C, 6'o53);
        checks++;
        if (upd_total - upd_base !== 1) begin
            errors++;
            $display("FAIL arst_dll_updates: got %0d want 1", upd_total - upd_base);
        end
    endtask

    // Lane1 dead on the first sweep, passes 2-4 afterwards.
    task automatic test_retry();
        bit d, e;
        set_maps(8'h3C, 8'h00, 8'h3C, 8'h1C);
        start_cal();
        wait_end(5000, d, e);
`ifdef ECPDDR_RDCAL_RETRY_EN
        checks++;
        if (d !== 1'b1 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL retry_done: done=%b err=%b, want 1/0", d, o_err);
        end
        checks++;
        if (upd_total - upd_base !== 2) begin
            errors++;
            $display("FAIL retry_dll_updates: got %0d want 2", upd_total - upd_base);
        end
        checks++;
        if (o_rdsel !== 6'o33 || o_pass_map !== 16'h1C3C) begin
            errors++;
            $display("FAIL retry_result: rdsel=%o map=%h, want 33/1c3c", o_rdsel, o_pass_map);
        end
`else
        checks++;
        if (e !== 1'b1 || d !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL retry_fail: err=%b done=%b busy=%b, want 1/0/0", e, d, o_busy);
        end
        checks++;
        if (upd_total - upd_base !== 1) begin
            errors++;
            $display("FAIL retry_dll_updates: got %0d want 1", upd_total - upd_base);
        end
        checks++;
        if (o_rdsel !== '0 || o_pass_map !== 16'h003C) begin
            errors++;
            $display("FAIL retry_result: rdsel=%o map=%h, want 00/003c", o_rdsel, o_pass_map);
        end
`endif
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_pause_protocol();
        checks++;
        if (rdsel_viol !== 0) begin
            errors++;
            $display("FAIL pause_protocol: rdsel changed %0d times with pause low, want 0", rdsel_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_run();
        test_lock_timeout();
        test_rd_timeout();
        test_async_reset();
        test_retry();
        test_pause_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
